// File: rtl/sample_feeder.sv
// FT245 RX byte stream -> little-endian sample packer -> FWFT FIFO with prefill hysteresis.
// Optional underrun statistics counter enabled by defining SAMPLE_FEEDER_STATS_EN.
module sample_feeder #(
  parameter int BYTES_PER_SAMPLE = 2,
  parameter int DEPTH_WIDTH      = 8,
  parameter int PREFILL          = 128,
  parameter int HEARTBEAT_CYCLES = 10000,
  localparam int SAMPLE_W        = 8 * BYTES_PER_SAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [SAMPLE_W-1:0]   sample_o,
  output logic                  empty_o,
  input  logic                  read_i,
  input  logic                  flush_i,
  output logic [DEPTH_WIDTH:0]  level_o,
  output logic                  full_o,
  output logic                  underrun_o,
  output logic                  heartbeat_o
`ifdef SAMPLE_FEEDER_STATS_EN
  ,
  output logic [15:0]           underrun_cnt_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int LVL_W = DEPTH_WIDTH + 1;
  localparam int IDX_W = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
  localparam int HB_W  = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_SAMPLE - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_PRE   = LVL_W'(PREFILL);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HEARTBEAT_CYCLES - 1);

  typedef enum logic {FILL, RUN} state_t;

  logic [SAMPLE_W-1:0]    mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level;
  logic [IDX_W-1:0]       idx;
  logic [SAMPLE_W-1:0]    stage, word;
  state_t                 state, state_nxt;
  logic                   underrun_nxt;
  logic                   accept, last, wr_en, pop;
  logic [HB_W-1:0]        hb_cnt;

  assign full_o     = (level == LVL_FULL);
  assign in_ready_o = !full_o;
  assign level_o    = level;
  assign empty_o    = (state == FILL) || (level == '0);
  assign sample_o   = (level != '0) ? mem[rd_ptr] : '0;

  // flush_i wins over both the byte and the pop presented alongside it
  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign last   = (idx == IDX_LAST);
  assign wr_en  = accept && last;
  assign pop    = !flush_i && read_i && (state == RUN) && (level != '0);

  always_comb begin
    word = stage;
    for (int i = 0; i < BYTES_PER_SAMPLE; i++) begin
      if (IDX_W'(i) == idx) word[8*i +: 8] = in_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      stage  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      idx    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) begin
        stage <= word;
        idx   <= last ? '0 : idx + 1'b1;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      underrun_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      underrun_o <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    underrun_nxt = 1'b0;
    if (flush_i) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL: if (level >= LVL_PRE) state_nxt = RUN;
        RUN: begin
          // draining the last entry without a refill in the same cycle is an underrun
          if (pop && (level == LVL_ONE) && !wr_en) begin
            state_nxt    = FILL;
            underrun_nxt = 1'b1;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt      <= '0;
      heartbeat_o <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt      <= '0;
      heartbeat_o <= !heartbeat_o;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

`ifdef SAMPLE_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt_o <= '0;
    end else if (underrun_o && (underrun_cnt_o != 16'hFFFF)) begin
      underrun_cnt_o <= underrun_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// Randomized and directed bench for sample_feeder against a queue-based reference model.
module tb_sample_feeder;
  localparam int BPS = 2;
  localparam int DW  = 4;
  localparam int PRE = 4;
  localparam int HB  = 10;
  localparam int DEPTH = 1 << DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] sample_o;
  logic        empty_o;
  logic        read_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [DW:0] level_o;
  logic        full_o;
  logic        underrun_o;
  logic        heartbeat_o;
`ifdef SAMPLE_FEEDER_STATS_EN
  logic [15:0] underrun_cnt_o;
`endif

  sample_feeder #(
    .BYTES_PER_SAMPLE(BPS), .DEPTH_WIDTH(DW), .PREFILL(PRE), .HEARTBEAT_CYCLES(HB)
  ) dut (
    .clk(clk), .rst(rst), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .sample_o(sample_o), .empty_o(empty_o), .read_i(read_i),
    .flush_i(flush_i), .level_o(level_o), .full_o(full_o), .underrun_o(underrun_o),
    .heartbeat_o(heartbeat_o)
`ifdef SAMPLE_FEEDER_STATS_EN
    , .underrun_cnt_o(underrun_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference model state
  logic [15:0] q[$];
  logic [15:0] part;
  int          nbytes;
  bit          running;
  bit          und;
  int          cyc;
  int          ucnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    part = '0; nbytes = 0; running = 0; und = 0; cyc = 0; ucnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rd, input bit fl);
    int  sz;
    bit  wr, pp;
    sz = q.size(); wr = 0; pp = 0;
    cyc++;
    if (und && ucnt != 16'hFFFF) ucnt++;
    und = 0;
    if (fl) begin
      q.delete(); nbytes = 0; running = 0;
    end else begin
      if (v && sz < DEPTH) begin
        part[8*nbytes +: 8] = d;
        nbytes++;
        if (nbytes == BPS) begin wr = 1; nbytes = 0; end
      end
      if (running && rd && sz > 0) begin pp = 1; void'(q.pop_front()); end
      if (wr) q.push_back(part);
      if (!running) running = (sz >= PRE);
      else if (pp && sz == 1 && !wr) begin running = 0; und = 1; end
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = q.size();
    chk("level", 32'(level_o), 32'(sz));
    chk("full", 32'(full_o), 32'(sz == DEPTH));
    chk("ready", 32'(in_ready_o), 32'(sz != DEPTH));
    chk("empty", 32'(empty_o), 32'(!running || sz == 0));
    chk("sample", 32'(sample_o), (sz > 0) ? 32'(q[0]) : 32'd0);
    chk("underrun", 32'(underrun_o), 32'(und));
    chk("heartbeat", 32'(heartbeat_o), 32'((cyc / HB) % 2));
`ifdef SAMPLE_FEEDER_STATS_EN
    chk("ucnt", 32'(underrun_cnt_o), 32'(ucnt));
`endif
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rd, input bit fl);
    in_valid_i = v; in_data_i = d; read_i = rd; flush_i = fl;
    @(posedge clk);
    model_step(v, d, rd, fl);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  task automatic send_sample(input logic [15:0] s);
    step(1, s[7:0], 0, 0);
    step(1, s[15:8], 0, 0);
  endtask

  task automatic do_reset(input int hold);
    in_valid_i = 0; read_i = 0; flush_i = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (hold) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] bytes1 [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  int npulse;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // heartbeat from reset: toggles every 10 cycles
    for (int i = 1; i <= 40; i++) begin
      step(0, 8'h00, 0, 0);
      if (i == 10) chk("hb_c10", 32'(heartbeat_o), 32'd1);
      if (i == 20) chk("hb_c20", 32'(heartbeat_o), 32'd0);
    end

    // packing order and prefill
    for (int i = 0; i < 8; i++) step(1, bytes1[i], 0, 0);
    chk("first_word", 32'(sample_o), 32'h1234);
    chk("level4", 32'(level_o), 32'd4);
    idle(2);
    chk("run_empty", 32'(empty_o), 32'd0);
    npulse = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 8'h00, 1, 0);
      if (underrun_o) npulse++;
    end
    chk("underrun_pulses", 32'(npulse), 32'd1);
    for (int i = 0; i < 3; i++) send_sample(16'h1000 + 16'(i));
    idle(2);
    chk("fill_holds", 32'(empty_o), 32'd1);
    send_sample(16'h2000);
    idle(2);

    // fill to full, then one pop reopens the input
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 8'(i), 0, 0);
    chk("full_hit", 32'(full_o), 32'd1);
    step(0, 8'h00, 1, 0);
    chk("ready_back", 32'(in_ready_o), 32'd1);

    // flush discards a partial sample
    step(0, 8'h00, 0, 1);
    step(1, 8'hAA, 0, 0);
    step(1, 8'h55, 0, 1);
    chk("flush_level", 32'(level_o), 32'd0);
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    chk("flush_word", 32'(sample_o), 32'h2211);

    // concurrent last-byte write and pop at level 5
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) send_sample(16'h3000 + 16'(i));
    idle(2);
    step(1, 8'h77, 0, 0);
    step(1, 8'h88, 1, 0);
    chk("wr_pop_level", 32'(level_o), 32'd5);
    chk("wr_pop_no_und", 32'(underrun_o), 32'd0);

`ifdef SAMPLE_FEEDER_STATS_EN
    do_reset(3);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) send_sample(16'h4000 + 16'(i));
      idle(2);
      for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);
    end
    chk("ucnt3", 32'(underrun_cnt_o), 32'd3);
`else
    do_reset(3);
`endif

    // randomized traffic with varying read pressure
    for (int blk = 0; blk < 6; blk++) begin
      int rdp;
      rdp = blk % 3;
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 3) != 0, 8'($urandom),
             (rdp == 0) ? ($urandom_range(0, 3) == 0) :
             (rdp == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0),
             $urandom_range(0, 99) == 0);
      end
    end

    // reset in mid-stream loses queued data
    for (int i = 0; i < 6; i++) send_sample(16'(16'h5000 + 16'(i)));
    do_reset(2);
    chk("rst_level", 32'(level_o), 32'd0);
    idle(12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
